// File: rtl/rz_fsk_symbol_gen_if.sv
// rtl/rz_fsk_symbol_gen_if.sv - serial bit handshake between framer and symbol generator
interface rz_fsk_symbol_gen_if;
    logic bit_valid;
    logic bit_data;
    logic bit_ready;

    modport master (
        output bit_valid,
        output bit_data,
        input  bit_ready
    );

    modport slave (
        input  bit_valid,
        input  bit_data,
        output bit_ready
    );
endinterface

// File: rtl/rz_fsk_symbol_gen.sv
// rtl/rz_fsk_symbol_gen.sv - return-to-zero FSK baseband pulse generator, one symbol per bit
module rz_fsk_symbol_gen #(
    parameter int CNT_W = 8,
    parameter int PW_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [CNT_W-1:0]      cfg_sym_len_i,
    input  logic [CNT_W-1:0]      cfg_rz_len_i,
    input  logic [CNT_W-1:0]      cfg_per0_i,
    input  logic [CNT_W-1:0]      cfg_per1_i,
    input  logic [PW_W-1:0]       pw0_i,
    input  logic [PW_W-1:0]       pw1_i,
    rz_fsk_symbol_gen_if.slave    bit_if,
    output logic                  pulse_o,
    output logic                  busy_o,
    output logic                  sym_start_o,
    output logic                  underrun_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
    logic             bit_q, bit_d;
    logic [CNT_W-1:0] sym_len_q, sym_len_d;
    logic [CNT_W-1:0] rz_len_q, rz_len_d;
    logic [CNT_W-1:0] per0_q, per0_d;
    logic [CNT_W-1:0] per1_q, per1_d;
    logic [PW_W-1:0]  pw0_q, pw0_d;
    logic [PW_W-1:0]  pw1_q, pw1_d;
    logic             underrun_q, underrun_d;

    logic             active;
    logic             sym_last;
    logic             ready;
    logic             xfer;
    logic [CNT_W-1:0] per_l;
    logic [PW_W-1:0]  pw_l;
    logic [CNT_W:0]   hw_raw;
    logic [CNT_W:0]   hw_sat;

    // Both bit-value settings are latched; the stored bit picks the pair in use.
    assign per_l    = bit_q ? per1_q : per0_q;
    assign pw_l     = bit_q ? pw1_q  : pw0_q;
    assign hw_raw   = ({1'b0, per_l} >> 1) + {{(CNT_W + 1 - PW_W){1'b0}}, pw_l};
    assign hw_sat   = (hw_raw > {1'b0, per_l}) ? {1'b0, per_l} : hw_raw;

    assign active   = (state_q == ACTIVE);
    assign sym_last = active && (sym_cnt_q == sym_len_q - CNT_ONE);
    assign ready    = enable_i && ((state_q == IDLE) || sym_last);
    assign xfer     = bit_if.bit_valid && ready;

    assign bit_if.bit_ready = ready;
    assign busy_o           = active;
    assign sym_start_o      = active && (sym_cnt_q == CNT_ZERO);
    assign underrun_o       = underrun_q;
    assign pulse_o          = active && (sym_cnt_q < rz_len_q) && ({1'b0, sub_cnt_q} < hw_sat);

    always_comb begin
        state_d    = state_q;
        sym_cnt_d  = sym_cnt_q;
        sub_cnt_d  = sub_cnt_q;
        bit_d      = bit_q;
        sym_len_d  = sym_len_q;
        rz_len_d   = rz_len_q;
        per0_d     = per0_q;
        per1_d     = per1_q;
        pw0_d      = pw0_q;
        pw1_d      = pw1_q;
        underrun_d = 1'b0;

        if (!enable_i) begin
            state_d   = IDLE;
            sym_cnt_d = CNT_ZERO;
            sub_cnt_d = CNT_ZERO;
        end else if (xfer) begin
            state_d   = ACTIVE;
            sym_cnt_d = CNT_ZERO;
            sub_cnt_d = CNT_ZERO;
            bit_d     = bit_if.bit_data;
            sym_len_d = (cfg_sym_len_i == CNT_ZERO) ? CNT_ONE : cfg_sym_len_i;
            rz_len_d  = cfg_rz_len_i;
            per0_d    = (cfg_per0_i == CNT_ZERO) ? CNT_ONE : cfg_per0_i;
            per1_d    = (cfg_per1_i == CNT_ZERO) ? CNT_ONE : cfg_per1_i;
            pw0_d     = pw0_i;
            pw1_d     = pw1_i;
        end else if (active) begin
            if (sym_last) begin
                state_d    = IDLE;
                sym_cnt_d  = CNT_ZERO;
                sub_cnt_d  = CNT_ZERO;
                underrun_d = 1'b1;
            end else begin
                sym_cnt_d = sym_cnt_q + CNT_ONE;
                sub_cnt_d = (sub_cnt_q == per_l - CNT_ONE) ? CNT_ZERO : sub_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sym_cnt_q  <= CNT_ZERO;
            sub_cnt_q  <= CNT_ZERO;
            bit_q      <= 1'b0;
            sym_len_q  <= CNT_ZERO;
            rz_len_q   <= CNT_ZERO;
            per0_q     <= CNT_ZERO;
            per1_q     <= CNT_ZERO;
            pw0_q      <= '0;
            pw1_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sym_cnt_q  <= sym_cnt_d;
            sub_cnt_q  <= sub_cnt_d;
            bit_q      <= bit_d;
            sym_len_q  <= sym_len_d;
            rz_len_q   <= rz_len_d;
            per0_q     <= per0_d;
            per1_q     <= per1_d;
            pw0_q      <= pw0_d;
            pw1_q      <= pw1_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_rz_fsk_symbol_gen.sv
// tb/tb_rz_fsk_symbol_gen.sv - scoreboard bench for rz_fsk_symbol_gen
module tb_rz_fsk_symbol_gen;
    localparam int CNT_W = 8;
    localparam int PW_W  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [CNT_W-1:0] cfg_sym_len, cfg_rz_len, cfg_per0, cfg_per1;
    logic [PW_W-1:0]  pw0, pw1;
    logic             pulse, busy, sym_start, underrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit pulse;
        bit start;
        bit last;
    } rec_t;

    rec_t exp_q[$];

    rz_fsk_symbol_gen_if bif ();

    rz_fsk_symbol_gen #(.CNT_W(CNT_W), .PW_W(PW_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable),
        .cfg_sym_len_i (cfg_sym_len),
        .cfg_rz_len_i  (cfg_rz_len),
        .cfg_per0_i    (cfg_per0),
        .cfg_per1_i    (cfg_per1),
        .pw0_i         (pw0),
        .pw1_i         (pw1),
        .bit_if        (bif),
        .pulse_o       (pulse),
        .busy_o        (busy),
        .sym_start_o   (sym_start),
        .underrun_o    (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference waveform of one whole symbol from the settings present at transfer time.
    function automatic void push_symbol(input bit b);
        int   len, per, hw;
        rec_t r;
        len = (cfg_sym_len == 0) ? 1 : int'(cfg_sym_len);
        per = b ? int'(cfg_per1) : int'(cfg_per0);
        if (per == 0) per = 1;
        hw  = per / 2 + (b ? int'(pw1) : int'(pw0));
        if (hw > per) hw = per;
        for (int i = 0; i < len; i++) begin
            r.pulse = (i < int'(cfg_rz_len)) && ((i % per) < hw);
            r.start = (i == 0);
            r.last  = (i == len - 1);
            exp_q.push_back(r);
        end
    endfunction

    task automatic send_bit(input bit b);
        int n;
        n = 0;
        bif.bit_data  = b;
        bif.bit_valid = 1'b1;
        @(negedge clk);
        while (!bif.bit_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!bif.bit_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: bit_ready got 0 expected 1 within 300 cycles");
            bif.bit_valid = 1'b0;
            return;
        end
        @(posedge clk);
        push_symbol(b);
        #1;
        bif.bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int sl, input int rz, input int p0, input int p1,
                           input int w0, input int w1);
        cfg_sym_len = CNT_W'(sl);
        cfg_rz_len  = CNT_W'(rz);
        cfg_per0    = CNT_W'(p0);
        cfg_per1    = CNT_W'(p1);
        pw0         = PW_W'(w0);
        pw1         = PW_W'(w1);
    endtask

    initial begin : monitor
        bit   prev_last;
        rec_t r;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("busy_active", busy, 1'b1);
                chk("pulse", pulse, r.pulse);
                chk("sym_start", sym_start, r.start);
                chk("bit_ready_active", bif.bit_ready, enable && r.last);
                chk("underrun_active", underrun, 1'b0);
                prev_last = r.last;
            end else begin
                chk("busy_idle", busy, 1'b0);
                chk("pulse_idle", pulse, 1'b0);
                chk("sym_start_idle", sym_start, 1'b0);
                chk("bit_ready_idle", bif.bit_ready, enable);
                chk("underrun_idle", underrun, prev_last);
                prev_last = 1'b0;
            end
        end
    end

    initial begin : driver
        int n;
        rst           = 1'b1;
        enable        = 1'b0;
        bif.bit_valid = 1'b0;
        bif.bit_data  = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        idle(2);
        enable = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // bit 0: 11000 11000 then ten zeros, underrun afterwards
        set_cfg(20, 10, 5, 4, 0, 1);
        send_bit(1'b0);
        idle(24);

        // bit 1: 1110 x3
        set_cfg(12, 12, 5, 4, 0, 1);
        send_bit(1'b1);
        idle(15);

        // back-to-back stream 0,1,0
        set_cfg(20, 10, 5, 4, 0, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        idle(23);

        // saturation, period zero, rz zero
        set_cfg(9, 9, 3, 0, 3, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        set_cfg(9, 0, 3, 2, 3, 1);
        send_bit(1'b1);
        idle(12);

        // mid-symbol period change
        set_cfg(20, 20, 5, 4, 0, 0);
        send_bit(1'b0);
        idle(3);
        cfg_per0 = 8'd3;
        send_bit(1'b0);
        idle(22);

        // abort by enable
        set_cfg(20, 20, 5, 4, 1, 1);
        send_bit(1'b0);
        idle(6);
        enable = 1'b0;
        @(posedge clk);
        exp_q.delete();
        #1;
        enable = 1'b1;
        idle(3);

        // asynchronous reset mid-symbol
        set_cfg(20, 20, 0, 0, 0, 0);
        send_bit(1'b1);
        idle(4);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_pulse", pulse, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_sym_start", sym_start, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        chk("rst_bit_ready", bif.bit_ready, 1'b1);
        idle(2);
        rst = 1'b0;
        idle(2);

        // randomized stream
        for (int k = 0; k < 40; k++) begin
            set_cfg($urandom_range(0, 24), $urandom_range(0, 30), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 3));
            send_bit(1'($urandom_range(0, 1)));
            n = $urandom_range(0, 3);
            if (n != 0) idle(n * 8);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        idle(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
